// File: rtl/cp0_ctrl.sv
// Coprocessor 0 for the pipelined MIPS core, placed at the M stage.
// Holds SR, Cause, EPC, PRId, Count and Compare. It arbitrates external
// interrupts, the Count/Compare timer interrupt and synchronous exceptions.
// exc_take tells the hazard and PC logic to flush and redirect to the handler.
module cp0_ctrl #(
  parameter int          NUM_HWINT  = 5,
  parameter int          TIMER_EN   = 1,
  parameter int          COUNT_DIV  = 0,
  parameter logic [31:0] PRID_VALUE = 32'h0000_0056
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           addr,
  input  logic [31:0]          wdata,
  input  logic                 we,
  input  logic [31:0]          pc,
  input  logic                 bd,
  input  logic                 exc_req,
  input  logic [4:0]           exc_code,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic                 eret,
  output logic [31:0]          rdata,
  output logic [31:0]          epc,
  output logic                 exc_take,
  output logic                 int_req
);

  localparam logic       TEN     = (TIMER_EN != 0);
  localparam logic [4:0] HW_MASK = 5'((32'd1 << NUM_HWINT) - 32'd1);
  // IM/IP bits [15:10]; bits without a source line read as zero
  localparam logic [5:0] LINE_MASK = {TEN, HW_MASK};
  localparam logic [3:0] DIV_MAX   = 4'((32'd1 << COUNT_DIV) - 32'd1);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic [4:0]  ip_hw_q;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;
  logic [3:0]  div_q, div_d;

  logic [5:0]  ip_v;
  logic [5:0]  im_v;
  logic        wr_ok;
  logic        cnt_tick;
  logic        count_wr;
  logic        cmp_wr;
  logic [31:0] count_inc;

  // Interrupt/exception arbitration and the write-enable gate for mtc0
  always_comb begin
    ip_v      = {pend_q & TEN, ip_hw_q};
    im_v      = im_q & LINE_MASK;
    int_req   = (|(ip_v & im_v)) & ie_q & ~exl_q;
    exc_take  = int_req | (exc_req & ~exl_q);
    wr_ok     = we & ~exc_take;
    count_wr  = wr_ok && (addr == 5'd9);
    cmp_wr    = wr_ok && (addr == 5'd11);
    cnt_tick  = (div_q == DIV_MAX);
    count_inc = count_q + 32'd1;
    epc       = epc_q;
  end

  // Next-state for status, cause, EPC and the timer
  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    count_d   = count_q;
    compare_d = compare_q;
    pend_d    = pend_q;
    div_d     = cnt_tick ? 4'd0 : div_q + 4'd1;

    if (exc_take) begin
      // Taking an exception overrides any mtc0 or eret in the same cycle
      epc_d     = bd ? (pc - 32'd4) : pc;
      bd_d      = bd;
      exccode_d = int_req ? 5'd0 : exc_code;
      exl_d     = 1'b1;
    end else begin
      if (wr_ok && addr == 5'd12) begin
        im_d  = wdata[15:10];
        exl_d = wdata[1];
        ie_d  = wdata[0];
      end
      if (wr_ok && addr == 5'd14) epc_d = wdata;
      // eret wins over an SR write to EXL in the same cycle
      if (eret) exl_d = 1'b0;
    end

    // Timer keeps running regardless of exceptions; an explicit Count write
    // replaces the increment, a Compare write acknowledges the interrupt.
    if (count_wr)      count_d = wdata;
    else if (cnt_tick) count_d = count_inc;

    if (cmp_wr) begin
      compare_d = wdata;
      pend_d    = 1'b0;
    end else if (cnt_tick && !count_wr && count_inc == compare_q) begin
      pend_d = TEN;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      ip_hw_q   <= '0;
      bd_q      <= 1'b0;
      exccode_q <= '0;
      epc_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      pend_q    <= 1'b0;
      div_q     <= '0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      ip_hw_q   <= 5'(hwint);
      bd_q      <= bd_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
      div_q     <= div_d;
    end
  end

  // mfc0 read mux; reads see the registered value, never a same-cycle write
  always_comb begin
    rdata = 32'd0;
    case (addr)
      5'd12: rdata = {16'b0, im_v, 8'b0, exl_q, ie_q};
      5'd13: rdata = {bd_q, 15'b0, ip_v, 3'b0, exccode_q, 2'b0};
      5'd14: rdata = epc_q;
      5'd15: rdata = PRID_VALUE;
      5'd9:  rdata = TEN ? count_q : 32'd0;
      5'd11: rdata = TEN ? compare_q : 32'd0;
      default: rdata = 32'd0;
    endcase
  end

endmodule
